mandel_pixel_sequencer: RTL
===========================

# mandel_pixel_sequencer

Upstream frame sequencer for the Mandelbrot depth calculator. Scans an H_RES×V_RES pixel grid in raster order, generates the Q4.28 complex coordinate c for each pixel by incremental accumulation, and runs one calculator job per pixel via the calculator's start/done handshake. Each resulting depth is emitted on a valid/ready pixel stream toward the colour/frame-buffer stage.

## Interface
- WORD_LENGTH, 32: coordinate width (two's complement, Q4.28).
- FRAC, 28: fractional bits; documentation only, no arithmetic depends on it.
- H_RES, 640: pixels per line (≥1).
- V_RES, 480: lines per frame (≥1).

Ports:
- sysclk  in  1  clock; everything samples on its rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- frame_start  in  1  one-cycle request to render a frame; honoured only in IDLE.
- re_min  in  WORD_LENGTH  real part of the left column; latched at frame_start.
- im_max  in  WORD_LENGTH  imaginary part of the top line; latched at frame_start.
- step  in  WORD_LENGTH  pixel pitch, identical in x and y; latched at frame_start.
- max_iter  in  8  iteration limit; latched at frame_start.
- calc_start  out  1  one-cycle job start to the calculator.
- calc_re_c, calc_im_c  out  WORD_LENGTH  coordinate of the current job.
- calc_max_iter  out  8  latched max_iter.
- calc_done  in  1  calculator done, level; it stays high until the cycle after the next start.
- calc_depth  in  10  calculator final depth; valid while calc_done=1.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  downstream accept.
- pix_depth  out  10  depth of the emitted pixel.
- pix_x  out  $clog2(H_RES)  column of the emitted pixel.
- pix_y  out  $clog2(V_RES)  line of the emitted pixel.
- pix_last  out  1  emitted pixel is (H_RES-1, V_RES-1).
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel handshake.

## Operation
- States: IDLE, ISSUE, ARM, WAIT, EMIT.
- IDLE:
  - On frame_start, latch re_min, im_max, step and max_iter.
  - Load x=0, y=0, re_acc=re_min, im_acc=im_max.
  - Go to ISSUE.
- ISSUE: calc_start=1 for exactly this cycle, then go to ARM.
- ARM: one cycle in which calc_done is ignored, because a stale done from the previous job is still high. Go to WAIT.
- WAIT: when calc_done=1, register pix_depth=calc_depth, pix_x=x, pix_y=y and pix_last, then go to EMIT.
- EMIT: pix_valid=1. On pix_valid&&pix_ready:
  - If last pixel: go to IDLE and pulse frame_done.
  - Else if x==H_RES-1: x=0, y=y+1, re_acc=re_min, im_acc=im_acc-step, then go to ISSUE.
  - Else: x=x+1, re_acc=re_acc+step, then go to ISSUE.
- calc_re_c and calc_im_c are driven directly from re_acc and im_acc. They are held constant from ISSUE through WAIT, because the calculator re-reads c on every iteration.
- Arithmetic:
  - Additions and subtractions are WORD_LENGTH wide and wrap modulo 2^WORD_LENGTH, with no saturation.
  - No multiplier is used: the coordinate is re_min + x·step, im_max − y·step, reached by accumulation.
- frame_start outside IDLE is ignored. Latched parameters never change mid-frame.
- Reset mid-frame forces IDLE immediately. Any calculator job in flight is abandoned; its done is handled by the ARM rule of the next frame.

## Timing
- Reset values:
  - calc_start, pix_valid, pix_last, busy, frame_done: 0.
  - pix_depth, pix_x, pix_y, calc_re_c, calc_im_c, calc_max_iter: 0.
- All outputs are registered or decoded from registered state; none depends combinationally on pix_ready or calc_done.
- frame_start at edge t gives calc_start=1 in cycle t+1 and busy=1 from cycle t+1.
- Per-pixel overhead is ISSUE(1) + ARM(1) + WAIT-exit(1) + EMIT(≥1) cycles, on top of the calculator time.
- With pix_ready held high, pixel k's handshake is followed directly by pixel k+1's calc_start on the next cycle.
- Backpressure: while pix_valid && !pix_ready, pix_depth, pix_x, pix_y and pix_last stay stable and no new calc_start is issued.
- frame_done is asserted in the cycle after the final handshake, with busy=0 in that same cycle. frame_start in that cycle is accepted.

## Test plan
Directed bench: H_RES=4, V_RES=3, re_min=0xE0000000 (−2.0), im_max=0x10000000 (1.0), step=0x08000000 (0.5), calculator modelled with done asserted 5 cycles after start and held.

- Full frame, pix_ready=1:
  - 12 pixels in raster order.
  - Pixel (1,0) has c=(0xE8000000, 0x10000000).
  - Pixel (3,2) has c=(0xF8000000, 0x00000000) and pix_last=1.
  - frame_done is asserted once, then busy=0.
- Stale done:
  - The model leaves calc_done high between jobs.
  - Exactly 12 calc_start pulses; every pix_depth equals the depth returned for its own job (tag model depth = job index).
- Backpressure: pix_ready=0 for 7 cycles on pixel (2,1) → outputs stable, no calc_start during the stall, next calc_start one cycle after the ready handshake.
- frame_start during busy with different re_min: ignored; coordinates of the running frame are unchanged.
- Reset asserted in WAIT of pixel (1,1):
  - All outputs reach their reset values asynchronously.
  - A new frame_start restarts at (0,0) with c=(0xE0000000, 0x10000000).
- Wrap: re_min=0x7C000000, step=0x08000000 → pixel (1,0) re_c=0x84000000 (modulo wrap, no saturation).

Source files
------------

// File: rtl/mandel_pixel_sequencer_if.sv
// rtl/mandel_pixel_sequencer_if.sv - frame request, calculator job and pixel stream bundle
interface mandel_pixel_sequencer_if #(
  parameter int WORD_LENGTH = 32,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int XW          = (H_RES > 1) ? $clog2(H_RES) : 1,
  parameter int YW          = (V_RES > 1) ? $clog2(V_RES) : 1
);
  logic                   frame_start;
  logic [WORD_LENGTH-1:0] re_min;
  logic [WORD_LENGTH-1:0] im_max;
  logic [WORD_LENGTH-1:0] step;
  logic [7:0]             max_iter;

  logic                   calc_start;
  logic [WORD_LENGTH-1:0] calc_re_c;
  logic [WORD_LENGTH-1:0] calc_im_c;
  logic [7:0]             calc_max_iter;
  logic                   calc_done;
  logic [9:0]             calc_depth;

  logic                   pix_valid;
  logic                   pix_ready;
  logic [9:0]             pix_depth;
  logic [XW-1:0]          pix_x;
  logic [YW-1:0]          pix_y;
  logic                   pix_last;

  logic                   busy;
  logic                   frame_done;

  modport master (
    input  frame_start, re_min, im_max, step, max_iter,
    input  calc_done, calc_depth, pix_ready,
    output calc_start, calc_re_c, calc_im_c, calc_max_iter,
    output pix_valid, pix_depth, pix_x, pix_y, pix_last, busy, frame_done
  );

  modport slave (
    output frame_start, re_min, im_max, step, max_iter,
    output calc_done, calc_depth, pix_ready,
    input  calc_start, calc_re_c, calc_im_c, calc_max_iter,
    input  pix_valid, pix_depth, pix_x, pix_y, pix_last, busy, frame_done
  );
endinterface

// File: rtl/mandel_pixel_sequencer.sv
// rtl/mandel_pixel_sequencer.sv - raster scan of c coordinates, one calculator job per pixel
module mandel_pixel_sequencer #(
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                      sysclk,
  input  logic                      reset,
  mandel_pixel_sequencer_if.master  bus
);
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  if (H_RES < 1 || V_RES < 1 || FRAC >= WORD_LENGTH) begin : g_bad_params
    $error("mandel_pixel_sequencer: invalid H_RES/V_RES/FRAC");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t                 state;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [WORD_LENGTH-1:0] re_acc;
  logic [WORD_LENGTH-1:0] im_acc;
  logic [WORD_LENGTH-1:0] re_min_q;
  logic [WORD_LENGTH-1:0] step_q;
  logic [7:0]             max_iter_q;
  logic                   calc_start_q;
  logic                   pix_valid_q;
  logic [9:0]             pix_depth_q;
  logic [XW-1:0]          pix_x_q;
  logic [YW-1:0]          pix_y_q;
  logic                   pix_last_q;
  logic                   frame_done_q;

  // Coordinates come straight from the accumulators, which only move on a pixel handshake.
  assign bus.calc_start    = calc_start_q;
  assign bus.calc_re_c     = re_acc;
  assign bus.calc_im_c     = im_acc;
  assign bus.calc_max_iter = max_iter_q;
  assign bus.pix_valid     = pix_valid_q;
  assign bus.pix_depth     = pix_depth_q;
  assign bus.pix_x         = pix_x_q;
  assign bus.pix_y         = pix_y_q;
  assign bus.pix_last      = pix_last_q;
  assign bus.busy          = (state != S_IDLE);
  assign bus.frame_done    = frame_done_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      x            <= '0;
      y            <= '0;
      re_acc       <= '0;
      im_acc       <= '0;
      re_min_q     <= '0;
      step_q       <= '0;
      max_iter_q   <= '0;
      calc_start_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_depth_q  <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.frame_start) begin
            re_min_q     <= bus.re_min;
            step_q       <= bus.step;
            max_iter_q   <= bus.max_iter;
            x            <= '0;
            y            <= '0;
            re_acc       <= bus.re_min;
            im_acc       <= bus.im_max;
            calc_start_q <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          calc_start_q <= 1'b0;
          state        <= S_ARM;
        end
        // The previous job's done is still high here; it drops only after this cycle.
        S_ARM: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.calc_done) begin
            pix_depth_q <= bus.calc_depth;
            pix_x_q     <= x;
            pix_y_q     <= y;
            pix_last_q  <= (x == X_LAST) && (y == Y_LAST);
            pix_valid_q <= 1'b1;
            state       <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.pix_ready) begin
            pix_valid_q <= 1'b0;
            if (pix_last_q) begin
              frame_done_q <= 1'b1;
              state        <= S_IDLE;
            end else begin
              if (x == X_LAST) begin
                x      <= '0;
                y      <= y + 1'b1;
                re_acc <= re_min_q;
                im_acc <= im_acc - step_q;
              end else begin
                x      <= x + 1'b1;
                re_acc <= re_acc + step_q;
              end
              calc_start_q <= 1'b1;
              state        <= S_ISSUE;
            end
          end
        end
        default: begin
          calc_start_q <= 1'b0;
          pix_valid_q  <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end
endmodule
